// File: rtl/nn_lstm_pkg.sv
// Shared types and arithmetic helpers for the LSTM weight-update slice.
// Register widths live here so the saturate/clamp helpers can be shared.
package nn_lstm_pkg;

    localparam int NN_W     = 8;
    localparam int NN_G     = 10;
    localparam int NN_W_MAX = 2 ** (NN_W - 1) - 1;
    localparam int NN_G_MAX = 2 ** (NN_G - 1) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_APPLY = 2'd2,
        ST_CLEAR = 2'd3
    } wu_state_e;

    // Symmetric saturation keeps -2^(G-1) out of the accumulator.
    function automatic logic signed [NN_G-1:0] sat_step(input logic signed [NN_G-1:0] g,
                                                        input logic up);
        logic signed [NN_G-1:0] lim;
        lim = NN_G'(NN_G_MAX);
        if (up)
            return (g == lim) ? g : g + NN_G'(1);
        else
            return (g == -lim) ? g : g - NN_G'(1);
    endfunction

    function automatic logic signed [NN_W-1:0] clamp_w(input logic signed [NN_G:0] v);
        logic signed [NN_G:0] lim;
        logic signed [NN_G:0] r;
        lim = (NN_G + 1)'(NN_W_MAX);
        if (v > lim)
            r = lim;
        else if (v < -lim)
            r = -lim;
        else
            r = v;
        return r[NN_W-1:0];
    endfunction

endpackage

// File: rtl/nn_lstm_wu_cell.sv
// One weight: gradient counter, weight register and polar stream comparator.
// apply takes the SGD step; clear zeroes the gradient for the next window.
module nn_lstm_wu_cell
    import nn_lstm_pkg::*;
#(
    parameter int ETA_SHIFT = 4,
    parameter int W_INIT    = 0
) (
    input  logic            clk,
    input  logic            init,
    input  logic            inc,
    input  logic            dec,
    input  logic            apply,
    input  logic            clear,
    input  logic [NN_W-2:0] rnd,
    output logic            alpha,
    output logic            sign_alpha
);

    logic signed [NN_G-1:0] grad;
    logic signed [NN_W-1:0] w;
    logic signed [NN_G-1:0] grad_sh;
    logic signed [NN_G:0]   w_ext;
    logic signed [NN_G:0]   step_ext;
    logic signed [NN_G:0]   w_sum;
    logic [NN_W-1:0]        w_abs;

    assign grad_sh  = grad >>> ETA_SHIFT;
    assign w_ext    = {{(NN_G + 1 - NN_W){w[NN_W-1]}}, w};
    assign step_ext = {grad_sh[NN_G-1], grad_sh};
    assign w_sum    = w_ext - step_ext;
    // w never holds -2^(W-1), so the magnitude always fits in W-1 bits.
    assign w_abs    = w[NN_W-1] ? (~w + NN_W'(1)) : w;

    always_ff @(posedge clk) begin
        if (init) begin
            grad       <= '0;
            w          <= NN_W'(W_INIT);
            alpha      <= 1'b0;
            sign_alpha <= 1'b0;
        end else begin
            if (clear)
                grad <= '0;
            else if (inc || dec)
                grad <= sat_step(grad, inc);
            if (apply)
                w <= clamp_w(w_sum);
            alpha      <= (w_abs[NN_W-2:0] > rnd);
            sign_alpha <= w[NN_W-1];
        end
    end

endmodule

// File: rtl/nn_lstm_weight_update_polar.sv
// Per-gate weight update: accumulates polar delta*x gradients over a BPTT window,
// applies a shifted SGD step and regenerates the weights as polar streams.
module nn_lstm_weight_update_polar
    import nn_lstm_pkg::*;
#(
    parameter int N         = 3,
    parameter int ETA_SHIFT = 4,
    parameter int W_INIT    = 0
) (
    input  logic            CLK,
    input  logic            INIT,
    input  logic            start,
    input  logic            en,
    input  logic            delta,
    input  logic            SIGN_delta,
    input  logic [N-1:0]    x,
    input  logic [N-1:0]    SIGN_x,
    input  logic            window_end,
    input  logic [NN_W-2:0] rnd,
    output logic [N-1:0]    alpha,
    output logic [N-1:0]    SIGN_alpha,
    output logic            busy,
    output logic            upd_done,
    output logic [1:0]      state_dbg
);

    wu_state_e    state;
    wu_state_e    next_state;
    logic [N-1:0] inc;
    logic [N-1:0] dec;
    logic         accum_en;
    logic         apply;
    logic         clear;

    // en is a sample-valid qualifier with no backpressure: every cycle with en=1 in
    // ACCUM is consumed, and window_end only counts on such a cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_ACCUM;
            ST_ACCUM: if (en && window_end) next_state = ST_APPLY;
            ST_APPLY: next_state = ST_CLEAR;
            ST_CLEAR: next_state = ST_ACCUM;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    assign accum_en  = (state == ST_ACCUM) && en && delta;
    assign inc       = {N{accum_en}} & x & ~({N{SIGN_delta}} ^ SIGN_x);
    assign dec       = {N{accum_en}} & x &  ({N{SIGN_delta}} ^ SIGN_x);
    assign apply     = (state == ST_APPLY);
    assign clear     = (state == ST_CLEAR);
    assign busy      = (state != ST_IDLE);
    assign upd_done  = clear;
    assign state_dbg = state;

    for (genvar n = 0; n < N; n++) begin : g_cell
        nn_lstm_wu_cell #(
            .ETA_SHIFT (ETA_SHIFT),
            .W_INIT    (W_INIT)
        ) u_cell (
            .clk        (CLK),
            .init       (INIT),
            .inc        (inc[n]),
            .dec        (dec[n]),
            .apply      (apply),
            .clear      (clear),
            .rnd        (rnd),
            .alpha      (alpha[n]),
            .sign_alpha (SIGN_alpha[n])
        );
    end

endmodule

// File: tb/tb_nn_lstm_weight_update_polar.sv
// Directed bench for the polar LSTM weight-update block: a driver issues windows and
// stream probes, a monitor checks the probed alpha/SIGN_alpha against a weight model.
module tb_nn_lstm_weight_update_polar;
    import nn_lstm_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       delta = 1'b0;
    logic       sign_delta = 1'b0;
    logic [2:0] x = '0;
    logic [2:0] sign_x = '0;
    logic       window_end = 1'b0;
    logic [6:0] rnd = '0;
    logic [2:0] alpha;
    logic [2:0] sign_alpha;
    logic       busy;
    logic       upd_done;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;
    logic [5:0] exp_q[$];
    logic probe = 1'b0;
    logic probe_d = 1'b0;
    int alpha2_ones = 0;
    int w_m[N];
    int g_m[N];

    nn_lstm_weight_update_polar #(.N(N), .ETA_SHIFT(4), .W_INIT(0)) dut (
        .CLK        (clk),
        .INIT       (init),
        .start      (start),
        .en         (en),
        .delta      (delta),
        .SIGN_delta (sign_delta),
        .x          (x),
        .SIGN_x     (sign_x),
        .window_end (window_end),
        .rnd        (rnd),
        .alpha      (alpha),
        .SIGN_alpha (sign_alpha),
        .busy       (busy),
        .upd_done   (upd_done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [5:0] exp_stream(input int r);
        logic [5:0] e;
        e = '0;
        for (int n = 0; n < N; n++) begin
            e[n]     = (iabs(w_m[n]) > r);
            e[n + 3] = (w_m[n] < 0);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            w_m[n] = 0;
            g_m[n] = 0;
        end
    endtask

    task automatic model_apply();
        int s;
        int v;
        for (int n = 0; n < N; n++) begin
            s = (g_m[n] < 0) ? -((-g_m[n] + 15) / 16) : g_m[n] / 16;
            v = w_m[n] - s;
            if (v > 127) v = 127;
            if (v < -127) v = -127;
            w_m[n] = v;
            g_m[n] = 0;
        end
    endtask

    task automatic do_reset();
        init = 1'b1;
        start = 1'b0;
        en = 1'b0;
        delta = 1'b0;
        window_end = 1'b0;
        x = '0;
        sign_x = '0;
        step();
        init = 1'b0;
        model_reset();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic sample(input logic d, input logic sd, input logic [2:0] xv,
                          input logic [2:0] sxv, input logic last);
        int g;
        en = 1'b1;
        delta = d;
        sign_delta = sd;
        x = xv;
        sign_x = sxv;
        window_end = last;
        step();
        en = 1'b0;
        delta = 1'b0;
        window_end = 1'b0;
        x = '0;
        for (int n = 0; n < N; n++) begin
            if (d && xv[n]) begin
                g = g_m[n] + ((sd ^ sxv[n]) ? -1 : 1);
                if (g > 511) g = 511;
                if (g < -511) g = -511;
                g_m[n] = g;
            end
        end
    endtask

    task automatic probe_at(input int r);
        rnd = 7'(r);
        probe = 1'b1;
        exp_q.push_back(exp_stream(r));
        step();
        probe = 1'b0;
    endtask

    task automatic probe_weights();
        int a;
        probe_at(0);
        for (int n = 0; n < N; n++) begin
            a = iabs(w_m[n]);
            if (a > 0) probe_at(a - 1);
            probe_at(a);
        end
    endtask

    // Runs one window from ACCUM, checks the APPLY/CLEAR sequence, then probes weights.
    task automatic window(input int cnt, input logic d, input logic sd, input logic [2:0] xv,
                          input logic [2:0] sxv, input bit gap, input bit poke);
        for (int i = 0; i < cnt; i++) begin
            sample(d, sd, xv, sxv, i == cnt - 1);
            if (gap && (i % 2 == 0) && (i != cnt - 1)) begin
                delta = 1'b1;
                x = 3'b111;
                window_end = 1'b1;
                step();
                delta = 1'b0;
                x = '0;
                window_end = 1'b0;
            end
        end
        chk("apply_state", state_dbg, ST_APPLY);
        chk("apply_upd_done", upd_done, 0);
        chk("apply_busy", busy, 1);
        model_apply();
        step();
        chk("clear_state", state_dbg, ST_CLEAR);
        chk("clear_upd_done", upd_done, 1);
        if (poke) begin
            en = 1'b1;
            delta = 1'b1;
            x = 3'b111;
            window_end = 1'b1;
        end
        step();
        en = 1'b0;
        delta = 1'b0;
        x = '0;
        window_end = 1'b0;
        chk("post_clear_state", state_dbg, ST_ACCUM);
        chk("post_clear_upd_done", upd_done, 0);
        probe_weights();
    endtask

    always @(posedge clk) probe_d <= probe;

    always @(negedge clk) begin
        if (probe_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got probe expected queued entry");
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                chk("alpha", alpha, e[2:0]);
                chk("sign_alpha", sign_alpha, e[5:3]);
                if (alpha[2]) alpha2_ones++;
            end
        end
    end

    initial begin
        model_reset();
        // Reset state and INIT mid-window
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_upd_done", upd_done, 0);
        chk("rst_alpha", alpha, 0);
        chk("rst_sign", sign_alpha, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        en = 1'b1;
        window_end = 1'b1;
        delta = 1'b1;
        x = 3'b111;
        step();
        en = 1'b0;
        window_end = 1'b0;
        delta = 1'b0;
        x = '0;
        chk("we_in_idle_state", state_dbg, ST_IDLE);
        do_start();
        chk("start_state", state_dbg, ST_ACCUM);
        chk("start_busy", busy, 1);
        for (int i = 0; i < 37; i++) sample(1'b1, 1'b0, 3'b001, 3'b000, 1'b0);
        init = 1'b1;
        step();
        init = 1'b0;
        model_reset();
        chk("init_state", state_dbg, ST_IDLE);
        chk("init_busy", busy, 0);
        chk("init_alpha", alpha, 0);
        chk("init_upd_done", upd_done, 0);
        start = 1'b1;
        en = 1'b1;
        window_end = 1'b1;
        step();
        start = 1'b0;
        en = 1'b0;
        window_end = 1'b0;
        chk("start_and_we_state", state_dbg, ST_ACCUM);
        window(1, 1'b0, 1'b0, 3'b001, 3'b000, 0, 0);

        // 64 positive samples: w0 0 -> -4
        do_reset();
        do_start();
        window(64, 1'b1, 1'b0, 3'b001, 3'b000, 0, 0);

        // Negative delta, 160 samples per window, up to the +127 clamp
        do_reset();
        do_start();
        for (int k = 0; k < 14; k++) window(160, 1'b1, 1'b1, 3'b001, 3'b000, 0, 0);

        // grad1 = -1 rounds toward -inf, w1 becomes +1
        window(1, 1'b1, 1'b0, 3'b010, 3'b010, 0, 0);

        // 600 same-sign samples saturate grad2; en=0 cycles are ignored
        do_reset();
        do_start();
        window(600, 1'b1, 1'b0, 3'b100, 3'b000, 1, 0);

        // Build w2 = +64, then sweep rnd
        do_reset();
        do_start();
        window(496, 1'b1, 1'b1, 3'b100, 3'b000, 0, 0);
        window(496, 1'b1, 1'b1, 3'b100, 3'b000, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_accum_state", state_dbg, ST_ACCUM);
        window(32, 1'b1, 1'b1, 3'b100, 3'b000, 0, 1);
        step();
        alpha2_ones = 0;
        for (int r = 0; r < 128; r++) probe_at(r);
        step();
        chk("alpha2_ones", alpha2_ones, 64);
        chk("scoreboard_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
